// File: rtl/fir_mac_sequencer.sv
// FIR MAC sequencer: sample intake, RAM address walk, pipeline controls, 2-deep output FIFO.
// Optional `FIR_TLAST_CHK_EN adds a sticky err_tlast flag for misplaced ss_tlast.
module fir_mac_sequencer #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   ap_start,
   input  logic [31:0]            data_length,
   output logic                   ap_idle,
   output logic                   ap_done,
   input  logic                   ss_tvalid,
   input  logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tlast,
   output logic                   ss_tready,
   output logic                   data_EN,
   output logic [3:0]             data_WE,
   output logic [pADDR_WIDTH-1:0] data_A,
   output logic [pDATA_WIDTH-1:0] data_Di,
   output logic                   tap_EN,
   output logic [pADDR_WIDTH-1:0] tap_A,
   output logic                   Data_control,
   output logic                   Tape_control,
   output logic                   adder_rst_control,
   output logic                   output_control,
   output logic                   cal_rst_n,
   input  logic [pDATA_WIDTH-1:0] y_output,
   output logic                   sm_tvalid,
   output logic [pDATA_WIDTH-1:0] sm_tdata,
   output logic                   sm_tlast,
   input  logic                   sm_tready
`ifdef FIR_TLAST_CHK_EN
   ,
   output logic                   err_tlast
`endif
);

   localparam int PW = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
   localparam logic [PW-1:0] LAST = PW'(Tape_Num - 1);

   typedef enum logic [1:0] {IDLE, CLR, WAIT_IN, MAC} state_t;

   state_t                   state;
   logic                     busy;
   logic [31:0]              len;
   logic [31:0]              n;
   logic [31:0]              out_cnt;
   logic [PW-1:0]            wr_ptr;
   logic [PW-1:0]            rd_ptr;
   logic [PW-1:0]            k;
   logic [1:0]               inflight;
   logic [1:0]               fifo_cnt;
   logic                     wr_idx;
   logic                     rd_idx;
   logic [pDATA_WIDTH-1:0]   fifo_d [2];
   logic [1:0]               fifo_l;
   logic [2:0]               out_sr;

   logic go;
   logic hs;
   logic mac;
   logic last_k;
   logic mac_last;
   logic push;
   logic pop;
   logic room;

   assign go       = (state == IDLE) && ap_start && !busy;
   assign mac      = (state == MAC);
   assign last_k   = (k == LAST);
   assign mac_last = mac && last_k;
   assign push     = output_control;

   assign sm_tvalid = (fifo_cnt != 2'd0);
   assign sm_tdata  = fifo_d[rd_idx];
   assign sm_tlast  = sm_tvalid && fifo_l[rd_idx];
   assign pop       = sm_tvalid && sm_tready;
   assign ap_done   = pop && fifo_l[rd_idx];

   // A pop this cycle frees a slot for a sample accepted this cycle.
   assign room = ({1'b0, inflight} + {1'b0, fifo_cnt}) < (3'd2 + {2'b00, pop});
   assign ss_tready = (state == WAIT_IN) && room;
   assign hs        = ss_tvalid && ss_tready;

   always_comb begin
      data_EN = 1'b0;
      data_WE = 4'h0;
      data_A  = '0;
      data_Di = '0;
      tap_EN  = 1'b0;
      tap_A   = '0;
      if (hs) begin
         data_EN = 1'b1;
         data_WE = 4'hF;
         data_A  = pADDR_WIDTH'({wr_ptr, 2'b00});
         data_Di = ss_tdata;
      end else if (mac) begin
         data_EN = 1'b1;
         data_A  = pADDR_WIDTH'({rd_ptr, 2'b00});
         tap_EN  = 1'b1;
         tap_A   = pADDR_WIDTH'({k, 2'b00});
      end
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state             <= IDLE;
         busy              <= 1'b0;
         ap_idle           <= 1'b1;
         len               <= '0;
         n                 <= '0;
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         k                 <= '0;
         inflight          <= '0;
         out_sr            <= '0;
         Data_control      <= 1'b1;
         Tape_control      <= 1'b1;
         adder_rst_control <= 1'b0;
         output_control    <= 1'b0;
         cal_rst_n         <= 1'b1;
`ifdef FIR_TLAST_CHK_EN
         err_tlast         <= 1'b0;
`endif
      end else begin
         Data_control      <= 1'b1;
         Tape_control      <= 1'b1;
         adder_rst_control <= mac && (k == PW'(1));
         out_sr            <= {out_sr[1:0], mac_last};
         output_control    <= out_sr[2];
         cal_rst_n         <= !go;
         inflight          <= inflight + {1'b0, mac_last} - {1'b0, push};
         if (ap_done) begin
            busy    <= 1'b0;
            ap_idle <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (go) begin
                  state   <= CLR;
                  busy    <= 1'b1;
                  ap_idle <= 1'b0;
                  len     <= data_length;
`ifdef FIR_TLAST_CHK_EN
                  err_tlast <= 1'b0;
`endif
               end
            end
            CLR: begin
               wr_ptr <= '0;
               n      <= '0;
               k      <= '0;
               state  <= WAIT_IN;
            end
            WAIT_IN: begin
               if (hs) begin
                  rd_ptr <= wr_ptr;
                  k      <= '0;
                  state  <= MAC;
`ifdef FIR_TLAST_CHK_EN
                  if (ss_tlast != (n == len - 32'd1))
                     err_tlast <= 1'b1;
`endif
               end
            end
            MAC: begin
               // Terms older than the first sample read stale RAM: zero them.
               Data_control <= (32'(k) > n);
               Tape_control <= 1'b0;
               k            <= k + PW'(1);
               rd_ptr       <= (rd_ptr == '0) ? LAST : rd_ptr - PW'(1);
               if (last_k) begin
                  wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
                  n      <= n + 32'd1;
                  state  <= (n + 32'd1 == len) ? IDLE : WAIT_IN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         fifo_cnt  <= '0;
         wr_idx    <= 1'b0;
         rd_idx    <= 1'b0;
         out_cnt   <= '0;
         fifo_d[0] <= '0;
         fifo_d[1] <= '0;
         fifo_l    <= '0;
      end else begin
         if (state == CLR) begin
            out_cnt <= '0;
         end else if (push) begin
            fifo_d[wr_idx] <= y_output;
            fifo_l[wr_idx] <= (out_cnt == len - 32'd1);
            wr_idx         <= ~wr_idx;
            out_cnt        <= out_cnt + 32'd1;
         end
         if (pop)
            rd_idx <= ~rd_idx;
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

`ifndef FIR_TLAST_CHK_EN
   logic unused_tlast;
   assign unused_tlast = ss_tlast;
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with behavioural RAMs and MAC pipeline.
// Define FIR_TLAST_CHK_EN to also exercise err_tlast.
module tb_fir_mac_sequencer;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int NT = 11;

   logic          clk;
   logic          rst_n;
   logic          ap_start;
   logic [31:0]   data_length;
   logic          ap_idle;
   logic          ap_done;
   logic          ss_tvalid;
   logic [DW-1:0] ss_tdata;
   logic          ss_tlast;
   logic          ss_tready;
   logic          data_EN;
   logic [3:0]    data_WE;
   logic [AW-1:0] data_A;
   logic [DW-1:0] data_Di;
   logic          tap_EN;
   logic [AW-1:0] tap_A;
   logic          Data_control;
   logic          Tape_control;
   logic          adder_rst_control;
   logic          output_control;
   logic          cal_rst_n;
   logic [DW-1:0] y_output;
   logic          sm_tvalid;
   logic [DW-1:0] sm_tdata;
   logic          sm_tlast;
   logic          sm_tready;
`ifdef FIR_TLAST_CHK_EN
   logic          err_tlast;
`endif

   fir_mac_sequencer dut (
      .axis_clk          (clk),
      .axis_rst_n        (rst_n),
      .ap_start          (ap_start),
      .data_length       (data_length),
      .ap_idle           (ap_idle),
      .ap_done           (ap_done),
      .ss_tvalid         (ss_tvalid),
      .ss_tdata          (ss_tdata),
      .ss_tlast          (ss_tlast),
      .ss_tready         (ss_tready),
      .data_EN           (data_EN),
      .data_WE           (data_WE),
      .data_A            (data_A),
      .data_Di           (data_Di),
      .tap_EN            (tap_EN),
      .tap_A             (tap_A),
      .Data_control      (Data_control),
      .Tape_control      (Tape_control),
      .adder_rst_control (adder_rst_control),
      .output_control    (output_control),
      .cal_rst_n         (cal_rst_n),
      .y_output          (y_output),
      .sm_tvalid         (sm_tvalid),
      .sm_tdata          (sm_tdata),
      .sm_tlast          (sm_tlast),
      .sm_tready         (sm_tready)
`ifdef FIR_TLAST_CHK_EN
      ,
      .err_tlast         (err_tlast)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM and MAC pipeline models
   logic [DW-1:0] data_mem [NT] = '{default: 32'hDEAD_BEEF};
   logic [DW-1:0] tap_mem [NT];
   logic [DW-1:0] data_do, tap_do, d_reg, t_reg, mul_reg, add_reg;

   always @(posedge clk) begin
      if (data_EN) begin
         if (data_WE == 4'hF) data_mem[data_A[AW-1:2]] <= data_Di;
         data_do <= data_mem[data_A[AW-1:2]];
      end
      if (tap_EN) tap_do <= tap_mem[tap_A[AW-1:2]];
      if (!cal_rst_n) begin
         d_reg   <= '0;
         t_reg   <= '0;
         mul_reg <= '0;
         add_reg <= '0;
      end else begin
         d_reg   <= Data_control ? '0 : data_do;
         t_reg   <= Tape_control ? '0 : tap_do;
         mul_reg <= d_reg * t_reg;
         add_reg <= adder_rst_control ? '0 : add_reg + mul_reg;
      end
   end

   assign y_output = output_control ? add_reg : '0;

   int ovf = 0;
   always @(negedge clk) if (dut.fifo_cnt > 2'd2) ovf <= ovf + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   logic [31:0] src_data [32];
   int          src_n = 0;
   int          src_i = 0;
   int          tlast_idx = -1;

   int          hs_q[$];
   int          wa_q[$];
   logic [31:0] out_q[$];
   bit          last_q[$];
   int first_vld, adr_cyc, oc_cyc, cal_cyc, done_cnt, done_cyc, idle_cyc;
   int dc_low, tc_low, start_cyc;
   bit idle_prev;

   function automatic logic [31:0] oq(int i);
      return (i < out_q.size()) ? out_q[i] : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] hq(int i);
      return (i < hs_q.size()) ? hs_q[i] : -1;
   endfunction
   function automatic logic [31:0] wq(int i);
      return (i < wa_q.size()) ? wa_q[i] : -1;
   endfunction
   function automatic logic lq(int i);
      return (i < last_q.size()) ? last_q[i] : 1'bx;
   endfunction

   function automatic logic [31:0] ref_y(int n);
      logic [31:0] s = 0;
      for (int j = 0; j < NT && j <= n; j++) s += tap_mem[j] * src_data[n-j];
      return s;
   endfunction

   task automatic drive_src();
      ss_tvalid = (src_i < src_n);
      ss_tdata  = (src_i < src_n) ? src_data[src_i] : '0;
      ss_tlast  = (src_i == tlast_idx);
   endtask

   task automatic load_src(input int n, input int tl);
      src_n = n;
      src_i = 0;
      tlast_idx = tl;
      drive_src();
   endtask

   task automatic step();
      bit hs;
      @(negedge clk);
      hs = ss_tvalid && ss_tready;
      if (hs) hs_q.push_back(cyc);
      if (data_EN && data_WE == 4'hF) wa_q.push_back(int'(data_A));
      if (sm_tvalid && sm_tready) begin
         out_q.push_back(sm_tdata);
         last_q.push_back(sm_tlast);
      end
      if (sm_tvalid && first_vld < 0) first_vld = cyc;
      if (adder_rst_control && adr_cyc < 0) adr_cyc = cyc;
      if (output_control && oc_cyc < 0) oc_cyc = cyc;
      if (!cal_rst_n && cal_cyc < 0) cal_cyc = cyc;
      if (!Data_control) dc_low++;
      if (!Tape_control) tc_low++;
      if (ap_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (ap_idle && !idle_prev) idle_cyc = cyc;
      idle_prev = ap_idle;
      @(posedge clk);
      #1;
      if (hs) src_i++;
      drive_src();
   endtask

   task automatic start_job(input int len);
      hs_q.delete();
      wa_q.delete();
      out_q.delete();
      last_q.delete();
      first_vld = -1; adr_cyc = -1; oc_cyc = -1; cal_cyc = -1;
      done_cnt = 0; done_cyc = -1; idle_cyc = -1;
      dc_low = 0; tc_low = 0;
      data_length = len;
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_job(input string tag, input int budget, input int busy_at);
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > 0 && ap_idle) break;
         if (i == busy_at) begin
            ap_start = 1'b1;
            data_length = 2;
         end
         step();
         if (i == busy_at) begin
            ap_start = 1'b0;
            data_length = 0;
         end
      end
      check({tag, "_finished"}, done_cnt > 0 && ap_idle, 1);
      step();
   endtask

   task automatic check_rst(input string tag);
      check({tag, "_ctl"},
            {ap_idle, ap_done, ss_tready, data_EN, data_WE, tap_EN,
             Data_control, Tape_control, adder_rst_control,
             output_control, cal_rst_n, sm_tvalid, sm_tlast},
            {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0,
             1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      check({tag, "_addr"}, {8'h0, data_A, tap_A}, 0);
      check({tag, "_tdata"}, sm_tdata, 0);
   endtask

   initial begin
      int bad;
      int nlast;
      rst_n = 1'b1;
      ap_start = 1'b0;
      data_length = 0;
      sm_tready = 1'b0;
      idle_prev = 1'b1;
      load_src(0, -1);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_rst("reset");
      rst_n = 1'b1;
      step();

      // T1: taps k+1, samples 1,2,3
      for (int i = 0; i < NT; i++) tap_mem[i] = i + 1;
      src_data[0] = 1; src_data[1] = 2; src_data[2] = 3;
      load_src(3, 2);
      sm_tready = 1'b1;
      start_job(3);
      check("t1_idle_low", ap_idle, 0);
      wait_job("t1", 400, -1);
      check("t1_count", out_q.size(), 3);
      check("t1_y0", oq(0), 1);
      check("t1_y1", oq(1), 4);
      check("t1_y2", oq(2), 10);
      check("t1_last", {lq(0), lq(1), lq(2)}, 3'b001);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_idle_rise", idle_cyc, done_cyc + 1);
      check("t1_cal_rst", cal_cyc, start_cyc);
      check("t1_hs0", hq(0), start_cyc + 1);
      check("t1_adder_rst", adr_cyc, hq(0) + 3);
      check("t1_out_ctl", oc_cyc, hq(0) + NT + 4);
      check("t1_first_vld", first_vld, hq(0) + NT + 5);
      check("t1_dc_low", dc_low, 6);
      check("t1_tc_low", tc_low, 3 * NT);
`ifdef FIR_TLAST_CHK_EN
      check("t1_err_tlast", err_tlast, 0);
`endif

      // T2: continuous input, 20 samples
      for (int i = 0; i < 20; i++) src_data[i] = i + 1;
      load_src(20, 19);
      start_job(20);
      wait_job("t2", 600, -1);
      check("t2_hs_count", hs_q.size(), 20);
      bad = 0;
      for (int i = 1; i < hs_q.size(); i++)
         if (hs_q[i] - hs_q[i-1] != NT + 1) bad++;
      check("t2_gap_bad", bad, 0);
      check("t2_first_vld", first_vld, hq(0) + 16);
      check("t2_count", out_q.size(), 20);
      for (int i = 0; i < 20; i++) check($sformatf("t2_y%0d", i), oq(i), ref_y(i));
      nlast = 0;
      foreach (last_q[i]) nlast += int'(last_q[i]);
      check("t2_last_n", nlast, 1);
      check("t2_last_pos", lq(19), 1);

      // T3: output back-pressure
      src_data[0] = 5; src_data[1] = 6; src_data[2] = 7; src_data[3] = 8;
      load_src(4, 3);
      sm_tready = 1'b0;
      start_job(4);
      repeat (80) step();
      check("t3_hs_held", hs_q.size(), 2);
      check("t3_ready_low", ss_tready, 0);
      check("t3_valid_in", ss_tvalid, 1);
      check("t3_sm_valid", sm_tvalid, 1);
      check("t3_head", sm_tdata, 5);
      sm_tready = 1'b1;
      wait_job("t3", 400, -1);
      check("t3_hs_total", hs_q.size(), 4);
      check("t3_y0", oq(0), 5);
      check("t3_y1", oq(1), 16);
      check("t3_y2", oq(2), 34);
      check("t3_y3", oq(3), 60);
      check("t3_last", lq(3), 1);

      // T4: wrap with all-ones, plus ap_start while busy
      for (int i = 0; i < NT; i++) tap_mem[i] = 1;
      for (int i = 0; i < 13; i++) src_data[i] = 1;
      load_src(13, 12);
      start_job(13);
      wait_job("t4", 800, 40);
      check("t4_count", out_q.size(), 13);
      for (int i = 0; i < 13; i++)
         check($sformatf("t4_y%0d", i), oq(i), (i < NT) ? i + 1 : NT);
      check("t4_wa10", wq(10), 32'h28);
      check("t4_wa11", wq(11), 32'h0);
      check("t4_wa12", wq(12), 32'h4);
      check("t4_done_cnt", done_cnt, 1);
      check("t4_hs_count", hs_q.size(), 13);

      // T5: reset mid-MAC, then a fresh run
      load_src(3, 2);
      start_job(3);
      repeat (6) step();
      check("t5_in_mac", tap_EN, 1);
      rst_n = 1'b0;
      #1;
      check_rst("t5_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      load_src(1, 0);
      start_job(1);
      wait_job("t5", 200, -1);
      check("t5_count", out_q.size(), 1);
      check("t5_y0", oq(0), 1);
      check("t5_last", lq(0), 1);

`ifdef FIR_TLAST_CHK_EN
      // T6: misplaced ss_tlast
      for (int i = 0; i < NT; i++) tap_mem[i] = i + 1;
      src_data[0] = 1; src_data[1] = 2; src_data[2] = 3;
      load_src(3, 1);
      start_job(3);
      check("t6_err_clear", err_tlast, 0);
      wait_job("t6", 400, -1);
      check("t6_err_tlast", err_tlast, 1);
      check("t6_y0", oq(0), 1);
      check("t6_y1", oq(1), 4);
      check("t6_y2", oq(2), 10);
`endif

      check("fifo_ovf", ovf, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
